// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {a,b,c,d,e,f,g} patterns, element k is the glyph for hex value k.
    localparam logic [15:0][6:0] SEG_PATTERNS = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_lut.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module seg_hex_lut
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = SEG_PATTERNS[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with PWM brightness and frame-synchronous updates.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE   = 65536,
    parameter int BRIGHT_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic                    busy,
    output logic                    upd_ack,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int               CNT_W    = $clog2(PRESCALE);
    localparam int               IDX_W    = idx_width(NUM_DIGITS);
    localparam int               SLOT_ON  = PRESCALE >> BRIGHT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [BRIGHT_W-1:0]     bright_q;
    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              nibble;
    logic [6:0]              pattern;
    logic [CNT_W:0]          on_limit;
    logic                    slot_end;
    logic                    frame_end;
    logic                    lit;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_end  = slot_end && (idx == IDX_LAST);
    assign frame_tick = frame_end;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= '0;
            bright_q <= '0;
        end else begin
            if (cnt == '0) bright_q <= brightness;
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // NOTE: pending/display are plain registers, so they are reset; stale pending data must never surface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data <= '0;
            pend_dp   <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
            busy      <= 1'b0;
            upd_ack   <= 1'b0;
        end else begin
            upd_ack <= 1'b0;
            if (load) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
            end
            if (frame_end) begin
                busy <= 1'b0;
                // A load on the boundary cycle bypasses the pending stage.
                if (load) begin
                    disp_data <= data_in;
                    disp_dp   <= dp_in;
                    upd_ack   <= 1'b1;
                end else if (busy) begin
                    disp_data <= pend_data;
                    disp_dp   <= pend_dp;
                    upd_ack   <= 1'b1;
                end
            end else if (load) begin
                busy <= 1'b1;
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        logic run;
        blank = '0;
        run   = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            run      = run && (disp_data[4*k +: 4] == 4'h0) && !disp_dp[k];
            blank[k] = run;
        end
    end
`else
    assign blank = '0;
`endif

    assign nibble   = disp_data[{idx, 2'b00} +: 4];
    assign on_limit = (CNT_W + 1)'((int'(bright_q) + 1) * SLOT_ON);
    assign lit      = ({1'b0, cnt} < on_limit) && !blank[idx];

    seg_hex_lut u_lut (
        .nibble  (nibble),
        .pattern (pattern)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (lit) begin
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= pattern;
            dp  <= ~disp_dp[idx];
        end else begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 16-cycle slots, 2-bit brightness).
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int P  = 16;
    localparam int BW = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  data_in = '0;
    logic [3:0]   dp_in = '0;
    logic         load = 1'b0;
    logic [1:0]   brightness = 2'd3;
    logic         busy;
    logic         upd_ack;
    logic [6:0]   seg;
    logic         dp;
    logic [3:0]   an;
    logic         frame_tick;

    seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BRIGHT_W(BW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .brightness (brightness),
        .busy       (busy),
        .upd_ack    (upd_ack),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dpv;
        logic [1:0]  bright;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         on;
    } slot_t;

    slot_t      exp_q[$];
    vec_t       vecs[6];
    logic [6:0] hex_tab[16];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_pos(input int pos);
        for (int i = 0; i < 64 && (cyc % 64) != pos; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic wait_ack(input int bound, output int at, output logic last_busy);
        at = -1;
        last_busy = 1'b0;
        for (int i = 0; i < bound; i++) begin
            last_busy = busy;
            tick();
            if (upd_ack) begin
                at = cyc;
                return;
            end
        end
    endtask

    function automatic int next_base();
        return ((cyc / 64) + 1) * 64;
    endfunction

    // Expected per-slot appearance of one frame once v is on the display.
    task automatic push_expected(input vec_t v);
        for (int d = 0; d < 4; d++) begin
            slot_t s;
            logic  blk;
            blk = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (d != 0) begin
                blk = 1'b1;
                for (int j = d; j < 4; j++)
                    if (v.data[4*j +: 4] != 4'h0 || v.dpv[j]) blk = 1'b0;
            end
`endif
            s.an  = blk ? 4'hF : ~(4'b0001 << d);
            s.seg = blk ? 7'h7F : hex_tab[v.data[4*d +: 4]];
            s.dp  = blk ? 1'b1 : ~v.dpv[d];
            s.on  = blk ? 0 : (int'(v.bright) + 1) * 4;
            exp_q.push_back(s);
        end
    endtask

    // Watch the frame whose state starts at cycle base; outputs lag state by one cycle.
    task automatic observe(input int base);
        slot_t      s;
        int         on_cnt;
        int         stray;
        logic [3:0] an0;
        logic [6:0] seg0;
        logic       dp0;
        while (cyc < base + 1) tick();
        check("obs_align", cyc, base + 1);
        check("queue_size", exp_q.size(), 4);
        if (exp_q.size() < 4) begin
            exp_q.delete();
            return;
        end
        for (int k = 0; k < 64; k++) begin
            if (k > 0) tick();
            if (k == 0) check("ack_pulse_len", upd_ack, 0);
            if (k % 16 == 0) begin
                s = exp_q.pop_front();
                on_cnt = 0;
                stray  = 0;
                an0  = an;
                seg0 = seg;
                dp0  = dp;
            end
            if (an == 4'hF) begin
                if (seg !== 7'h7F || dp !== 1'b1) stray++;
            end else begin
                on_cnt++;
                if (an !== s.an || seg !== s.seg || dp !== s.dp) stray++;
            end
            if (k % 16 == 15) begin
                check($sformatf("slot%0d_an", k / 16), an0, s.an);
                check($sformatf("slot%0d_seg", k / 16), seg0, s.seg);
                check($sformatf("slot%0d_dp", k / 16), dp0, s.dp);
                check($sformatf("slot%0d_on", k / 16), on_cnt, s.on);
                check($sformatf("slot%0d_stray", k / 16), stray, 0);
            end
        end
    endtask

    task automatic run_vector(input vec_t v);
        int   ld;
        int   at;
        logic lb;
        brightness = v.bright;
        wait_pos(20);
        ld = cyc;
        push_expected(v);
        do_load(v.data, v.dpv);
        check("busy_set", busy, 1);
        wait_ack(120, at, lb);
        check("ack_cycle", at, ld + 44);
        check("busy_at_boundary", lb, 1);
        check("busy_clear", busy, 0);
        if (at < 0) exp_q.delete();
        else observe(at);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   ft_cnt;
        int   ft_first;
        int   off_cnt;
        int   acks;
        int   at;
        logic lb;

        hex_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
        vecs[0] = '{16'h12AF, 4'b0000, 2'd3};
        vecs[1] = '{16'h0050, 4'b0000, 2'd0};
        vecs[2] = '{16'h8C3E, 4'b0101, 2'd1};
        vecs[3] = '{16'h0000, 4'b1000, 2'd2};
        vecs[4] = '{16'h0007, 4'b0000, 2'd3};
        vecs[5] = '{16'h9640, 4'b0010, 2'd2};

        // Reset state and the free-running scan.
        #12;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1);
        check("rst_busy", busy, 0);
        check("rst_ack", upd_ack, 0);
        check("rst_ftick", frame_tick, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        tick();
        check("c1_an", an, 4'b1110);
        check("c1_seg", seg, 7'b0000001);
        ft_cnt = 0;
        ft_first = -1;
        off_cnt = 0;
        while (cyc < 130) begin
            if (frame_tick) begin
                ft_cnt++;
                if (ft_first < 0) ft_first = cyc;
            end
            if (cyc <= 64 && an == 4'hF) off_cnt++;
            if (cyc == 17) check("c17_an", an, 4'b1101);
            if (cyc == 33) check("c33_an", an, 4'b1011);
            if (cyc == 49) check("c49_an", an, 4'b0111);
            tick();
        end
        check("ftick_first", ft_first, 63);
        check("ftick_count", ft_cnt, 2);
        check("full_on_gaps", off_cnt, 0);

        for (int i = 0; i < 6; i++) run_vector(vecs[i]);

        // Last load before the boundary wins; exactly one acknowledge.
        brightness = 2'd3;
        wait_pos(10);
        do_load(16'h1111, 4'h0);
        wait_pos(40);
        push_expected('{16'h2222, 4'h0, 2'd3});
        do_load(16'h2222, 4'h0);
        wait_ack(120, at, lb);
        check("dbl_ack_pos", at % 64, 0);
        acks = 0;
        if (at >= 0) begin
            while (cyc < at + 64) begin
                tick();
                if (upd_ack) acks++;
            end
            check("dbl_extra_acks", acks, 0);
            observe(at + 64);
        end else begin
            exp_q.delete();
        end

        // Load exactly on the frame boundary goes straight to the display.
        wait_pos(63);
        check("bnd_ftick", frame_tick, 1);
        push_expected('{16'h4B6D, 4'b0001, 2'd3});
        do_load(16'h4B6D, 4'b0001);
        check("bnd_busy", busy, 0);
        check("bnd_ack", upd_ack, 1);
        observe(cyc);

        // Asynchronous reset while an update is pending.
        wait_pos(20);
        do_load(16'hABCD, 4'hF);
        wait_pos(40);
        check("mid_busy", busy, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_an", an, 4'hF);
        check("async_seg", seg, 7'h7F);
        check("async_busy", busy, 0);
        check("async_ack", upd_ack, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        tick();
        check("rel_an", an, 4'b1110);
        check("rel_seg", seg, 7'b0000001);
        acks = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (upd_ack) acks++;
        end
        check("rel_no_ack", acks, 0);
        push_expected('{16'h0000, 4'h0, 2'd3});
        observe(next_base());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits; legal range 1..16.
REQ-002 Parameter PRESCALE, default 65536, clk cycles per digit slot; SHALL be a multiple of 2**BRIGHT_W.
REQ-003 Parameter BRIGHT_W, default 3, brightness control width.
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 data_in  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k; digit 0 is least significant.
REQ-007 dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
REQ-008 load  in  1  single-cycle request to capture data_in/dp_in.
REQ-009 brightness  in  BRIGHT_W  on-time fraction per slot.
REQ-010 busy  out  1  high while a captured update awaits the frame boundary.
REQ-011 upd_ack  out  1  one-cycle pulse when the update reaches the display.
REQ-012 seg  out  7  cathodes {a,b,c,d,e,f,g} at seg[6:0], active-low.
REQ-013 dp  out  1  decimal point cathode, active-low.
REQ-014 an  out  NUM_DIGITS  anodes, active-low, at most one low at any time.
REQ-015 frame_tick  out  1  one-cycle pulse at each frame wrap.

Function
REQ-016 Prescale counter SHALL count 0..PRESCALE-1 and wrap; the wrap cycle advances digit index 0..NUM_DIGITS-1.
REQ-017 Digit index wrap NUM_DIGITS-1 -> 0 is the frame boundary; frame_tick SHALL pulse that cycle.
REQ-018 load SHALL copy data_in/dp_in into a pending register and set busy the next cycle; load while busy overwrites pending (last wins).
REQ-019 At the frame boundary with busy=1, the display register SHALL take pending, busy SHALL clear, upd_ack SHALL pulse the following cycle.
REQ-020 load coincident with the frame boundary: new data SHALL go straight to the display register, busy stays 0, upd_ack pulses.
REQ-021 brightness SHALL be sampled at slot start; the anode is on while prescale count < (brightness+1)*(PRESCALE>>BRIGHT_W), off otherwise.
REQ-022 seg, dp, an SHALL be registered, with one cycle latency after the digit index/prescale count they reflect.
REQ-023 Hex decode: 0-F standard patterns (e.g. 0 -> 7'b0000001, 8 -> 7'b0000000, F -> 7'b0111000).
REQ-024 While an is all ones, seg and dp SHALL be all ones.

Reset
REQ-025 rst_n low SHALL force, asynchronously: an all ones, seg 7'h7F, dp 1, busy 0, upd_ack 0, frame_tick 0, counters 0, pending/display registers 0.
REQ-026 Reset mid-update SHALL discard the pending data; after release digit 0 shows '0' and scanning restarts at slot 0.

Configuration
REQ-027 With macro SEG_LEADING_ZERO_BLANK_EN defined, a digit SHALL be blanked (anode held high) when it and all more-significant digits are 0 and none has dp set; digit 0 is never blanked.
REQ-028 Without SEG_LEADING_ZERO_BLANK_EN, every digit SHALL display, including leading zeros.

Structure
REQ-029 Package seg_pkg SHALL hold the 16-entry segment pattern constants, the SEG_OFF constant (7'h7F) and the digit-index width function.
REQ-030 Hex-to-segment lookup SHALL be sub-module seg_hex_lut (combinational, 4-bit in, 7-bit out).

Verification (NUM_DIGITS=4, PRESCALE=16, BRIGHT_W=2)
REQ-031 Reset release, brightness=3 -> cycle 1: an=4'b1110, seg=7'b0000001; an steps 1101,1011,0111 every 16 cycles; frame_tick every 64 cycles.
REQ-032 load 16'h12AF at cycle 20 -> busy=1 from cycle 21 to the boundary at cycle 63; upd_ack at 64; next frame shows F,A,2,1 on digits 0..3.
REQ-033 load 16'h1111, then 16'h2222 at a later cycle before the boundary -> only 2s displayed, one upd_ack.
REQ-034 brightness=0 -> each anode low 4 of 16 cycles; brightness=3 -> low for the full 16 cycles.
REQ-035 data 16'h0050, dp_in=0 -> with macro: an[3], an[2] never low, digits 1/0 show 5/0; without macro: digit 3 shows '0'.
REQ-036 rst_n low at cycle 40 while busy -> an=4'b1111 the same cycle with no clock edge; busy=0; no upd_ack after release.
